// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bubble word, boot address, fetch FSM states and opcodes.
// The fetch stage and its IF/ID register import this package.
package cpu_pkg;

    localparam logic [15:0] NOP_INSTR    = 16'hF000;
    localparam logic [15:0] RESET_VECTOR = 16'h0000;

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_JMP  = 4'b0111;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALTED
    } fetch_state_e;

    // Instructions are halfword aligned, so redirect targets drop bit 0.
    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush loads a bubble, hold freezes, load captures a fetch.
// Flush wins over hold so a redirect can kill the slot even while stalled.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [15:0] NOP_WORD = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic [15:0] instr_i,
    input  logic [15:0] pc_plus2_i,
    output logic [15:0] instr_o,
    output logic [15:0] pc_plus2_o,
    output logic        valid_o
);

    logic [15:0] instr_q;
    logic [15:0] pc_plus2_q;
    logic        valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q    <= NOP_WORD;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            instr_q    <= NOP_WORD;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else if (!hold_i && load_i) begin
            instr_q    <= instr_i;
            pc_plus2_q <= pc_plus2_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus2_o = pc_plus2_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, BOOT/RUN/HALTED control and a saturating fetch counter.
// The IF/ID register itself lives in ifid_reg.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
    parameter logic [15:0] NOP_INSTR    = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        if_flush,
    input  logic        halt,
    input  logic        pc_op,
    input  logic        b_jmp,
    input  logic [15:0] branch_target,
    input  logic [15:0] jump_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  count_q, count_d;
    logic [15:0]  pc_plus2;
    logic         ifid_load, ifid_flush, ifid_hold;

    assign pc_plus2 = pc_q + 16'd2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // RUN priority: halt, then redirect (even under stall), then stall, then flush.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_hold  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d    = ST_RUN;
                ifid_flush = 1'b1;
            end
            ST_RUN: begin
                if (halt) begin
                    state_d    = ST_HALTED;
                    ifid_flush = 1'b1;
                end else if (pc_op) begin
                    pc_d       = align_pc(b_jmp ? branch_target : jump_target);
                    ifid_flush = 1'b1;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else if (if_flush) begin
                    pc_d       = pc_plus2;
                    ifid_flush = 1'b1;
                end else begin
                    pc_d      = pc_plus2;
                    ifid_load = 1'b1;
                end
            end
            ST_HALTED: begin
                ifid_hold = 1'b1;
            end
            default: begin
                state_d    = ST_BOOT;
                ifid_flush = 1'b1;
            end
        endcase
    end

    assign count_d = (ifid_load && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;

    ifid_reg #(
        .NOP_WORD(NOP_INSTR)
    ) u_ifid (
        .clk       (clk),
        .reset     (reset),
        .load_i    (ifid_load),
        .flush_i   (ifid_flush),
        .hold_i    (ifid_hold),
        .instr_i   (imem_data),
        .pc_plus2_i(pc_plus2),
        .instr_o   (ifid_instr),
        .pc_plus2_o(ifid_pc_plus2),
        .valid_o   (ifid_valid)
    );

    assign imem_addr   = pc_q;
    assign halted      = (state_q == ST_HALTED);
    assign fetch_count = count_q;

endmodule
